// File: rtl/cache_types.sv
// rtl/cache_types.sv - shared types and constants for the cache-line/burst adaptor
package cache_types;

    localparam int LINE_WIDTH      = 256;
    localparam int BURST_WIDTH     = 64;
    localparam int BURSTS_PER_LINE = LINE_WIDTH / BURST_WIDTH;
    localparam int BEAT_CNT_WIDTH  = $clog2(BURSTS_PER_LINE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - splits 256-bit line transfers into 4x64-bit memory bursts
module cacheline_adaptor
    import cache_types::*;
(
    input  logic                   clk,
    input  logic                   rst,

    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,

    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(BURSTS_PER_LINE - 1);

    adaptor_state_t            state_q, state_d;
    logic [BEAT_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]               addr_q, addr_d;
    logic [LINE_WIDTH-1:0]     wline_q, wline_d;
    logic [LINE_WIDTH-1:0]     rline_q, rline_d;
    logic                      read_q, read_d;
    logic                      write_q, write_d;
    logic                      resp_q, resp_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        read_d  = read_q;
        write_d = write_q;
        resp_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A simultaneous read request is dropped; the write takes priority.
                if (write_i) begin
                    addr_d  = address_i;
                    wline_d = line_i;
                    cnt_d   = '0;
                    write_d = 1'b1;
                    state_d = WRITE;
                end else if (read_i) begin
                    addr_d  = address_i;
                    cnt_d   = '0;
                    read_d  = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    rline_d[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
                    cnt_d = cnt_q + BEAT_CNT_WIDTH'(1);
                    if (cnt_q == LAST_BEAT) begin
                        read_d  = 1'b0;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_d = cnt_q + BEAT_CNT_WIDTH'(1);
                    if (cnt_q == LAST_BEAT) begin
                        write_d = 1'b0;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
        end
    end

    // Write beat follows the counter directly so each accepted beat presents the next word.
    always_comb begin
        burst_o = wline_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH];
    end

    assign line_o    = rline_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks   = 0;
    int failures = 0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [63:0]  rd1 [4];
    logic [63:0]  wr1 [4];
    logic [63:0]  wr2 [4];
    logic [63:0]  rd2 [4];
    logic [63:0]  rd3 [4];
    logic [255:0] line_rd1;
    logic [255:0] exp_line;

    initial begin
        rd1[0] = 64'h1111_1111_1111_1111; rd1[1] = 64'h2222_2222_2222_2222;
        rd1[2] = 64'h3333_3333_3333_3333; rd1[3] = 64'h4444_4444_4444_4444;
        wr1[0] = 64'hAAAA_0000_0000_000A; wr1[1] = 64'hBBBB_0000_0000_000B;
        wr1[2] = 64'hCCCC_0000_0000_000C; wr1[3] = 64'hDDDD_0000_0000_000D;
        wr2[0] = 64'h0123_4567_89AB_CDEF; wr2[1] = 64'hFEDC_BA98_7654_3210;
        wr2[2] = 64'h0F0F_0F0F_0F0F_0F0F; wr2[3] = 64'hF0F0_F0F0_F0F0_F0F0;
        rd2[0] = 64'h5555_5555_5555_5555; rd2[1] = 64'h6666_6666_6666_6666;
        rd2[2] = 64'h7777_7777_7777_7777; rd2[3] = 64'h8888_8888_8888_8888;
        rd3[0] = 64'h9999_0000_0000_0001; rd3[1] = 64'h9999_0000_0000_0002;
        rd3[2] = 64'h9999_0000_0000_0003; rd3[3] = 64'h9999_0000_0000_0004;
        line_rd1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        tick();
        chk("rst_line_o", line_o, 256'h0);
        chk("rst_read_o", read_o, 1'b0);
        chk("rst_write_o", write_o, 1'b0);
        chk("rst_resp_o", resp_o, 1'b0);
        chk("rst_address_o", address_o, 32'h0);
        chk("rst_burst_o", burst_o, 64'h0);
        rst = 1'b0;
        tick();

        // Read with four back-to-back beats; resp_o lands in cycle 6 counting the request cycle.
        address_i = 32'h0000_1A60; read_i = 1'b1;
        tick();
        chk("rd1_read_o_rise", read_o, 1'b1);
        chk("rd1_address_o", address_o, 32'h0000_1A60);
        address_i = 32'h0000_FFE0;
        for (int k = 0; k < 4; k++) begin
            burst_i = rd1[k]; resp_i = 1'b1;
            chk("rd1_no_early_resp", resp_o, 1'b0);
            chk("rd1_read_o_held", read_o, 1'b1);
            tick();
        end
        resp_i = 1'b0; burst_i = '0;
        chk("rd1_resp_o", resp_o, 1'b1);
        chk("rd1_line_o", line_o, line_rd1);
        chk("rd1_read_o_fall", read_o, 1'b0);
        chk("rd1_address_stable", address_o, 32'h0000_1A60);
        read_i = 1'b0;
        tick();
        chk("rd1_resp_one_cycle", resp_o, 1'b0);

        // Write with two idle cycles between accepted beats.
        address_i = 32'h0000_2000; write_i = 1'b1;
        line_i = {wr1[3], wr1[2], wr1[1], wr1[0]};
        tick();
        chk("wr1_write_o_rise", write_o, 1'b1);
        chk("wr1_address_o", address_o, 32'h0000_2000);
        for (int k = 0; k < 4; k++) begin
            resp_i = 1'b1;
            chk($sformatf("wr1_burst_o_beat%0d", k), burst_o, wr1[k]);
            tick();
            resp_i = 1'b0;
            if (k < 3) begin
                for (int g = 0; g < 2; g++) begin
                    chk("wr1_write_o_gap", write_o, 1'b1);
                    chk("wr1_no_resp_gap", resp_o, 1'b0);
                    chk("wr1_burst_o_gap", burst_o, wr1[k+1]);
                    tick();
                end
            end
        end
        chk("wr1_resp_o", resp_o, 1'b1);
        chk("wr1_write_o_fall", write_o, 1'b0);
        chk("wr1_line_o_untouched", line_o, line_rd1);
        write_i = 1'b0;
        tick();
        chk("wr1_resp_one_cycle", resp_o, 1'b0);

        // Read and write together: write wins; resp_i stays high into DONE.
        address_i = 32'h0000_3000; write_i = 1'b1; read_i = 1'b1;
        line_i = {wr2[3], wr2[2], wr2[1], wr2[0]};
        tick();
        chk("both_write_o", write_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            resp_i = 1'b1;
            chk("both_read_o_low", read_o, 1'b0);
            chk($sformatf("both_burst_o_beat%0d", k), burst_o, wr2[k]);
            tick();
        end
        chk("both_resp_o", resp_o, 1'b1);
        chk("both_read_o_done", read_o, 1'b0);
        write_i = 1'b0; read_i = 1'b0; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        chk("done_resp_ignored_resp_o", resp_o, 1'b0);
        chk("done_resp_ignored_read_o", read_o, 1'b0);
        chk("done_resp_ignored_write_o", write_o, 1'b0);

        // resp_i pulses in IDLE must not move anything.
        tick();
        resp_i = 1'b0;
        tick();
        chk("idle_resp_line_o", line_o, line_rd1);
        chk("idle_resp_resp_o", resp_o, 1'b0);
        chk("idle_resp_read_o", read_o, 1'b0);
        chk("idle_resp_write_o", write_o, 1'b0);

        // Read at a new address: old line data survives until the first beat arrives.
        address_i = 32'h0000_5000; read_i = 1'b1;
        tick();
        chk("rd2_address_o", address_o, 32'h0000_5000);
        chk("rd2_line_o_held", line_o, line_rd1);
        tick();
        chk("rd2_line_o_held_gap", line_o, line_rd1);
        burst_i = rd2[0]; resp_i = 1'b1;
        tick();
        resp_i = 1'b0;
        exp_line = {rd1[3], rd1[2], rd1[1], rd2[0]};
        chk("rd2_line_o_beat0", line_o, exp_line);
        for (int k = 1; k < 4; k++) begin
            burst_i = rd2[k]; resp_i = 1'b1;
            tick();
        end
        resp_i = 1'b0;
        chk("rd2_resp_o", resp_o, 1'b1);
        chk("rd2_line_o", line_o, {rd2[3], rd2[2], rd2[1], rd2[0]});
        read_i = 1'b0;
        tick();

        // Reset after two beats of a read aborts it at once.
        address_i = 32'h0000_6000; read_i = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            burst_i = rd3[k]; resp_i = 1'b1;
            tick();
        end
        resp_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_read_o", read_o, 1'b0);
        chk("abort_line_o", line_o, 256'h0);
        chk("abort_address_o", address_o, 32'h0);
        chk("abort_resp_o", resp_o, 1'b0);
        chk("abort_burst_o", burst_o, 64'h0);
        tick();
        rst = 1'b0; read_i = 1'b0;
        tick();
        chk("abort_no_resp_after", resp_o, 1'b0);

        address_i = 32'h0000_6040; read_i = 1'b1;
        tick();
        chk("rd3_address_o", address_o, 32'h0000_6040);
        for (int k = 0; k < 4; k++) begin
            burst_i = rd3[k]; resp_i = 1'b1;
            chk("rd3_no_early_resp", resp_o, 1'b0);
            tick();
        end
        resp_i = 1'b0;
        chk("rd3_resp_o", resp_o, 1'b1);
        chk("rd3_line_o", line_o, {rd3[3], rd3[2], rd3[1], rd3[0]});
        read_i = 1'b0;
        tick();
        chk("rd3_resp_one_cycle", resp_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
